// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding and frame constants.
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_rx_state_t;
  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for an asynchronous input, resets to 1 (idle-high line).
module uart_rx_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk_in) begin
    if (rst) ff_q <= 2'b11;
    else     ff_q <= {ff_q[0], d_i};
  end
  assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver, 8N1 or 8E1 when UART_RX_PARITY_EN is defined.
// Each bit is sampled once at its midpoint; done strobes for one clock per completed frame.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       done,
  output logic       err,
  output logic       frame_err,
  output logic       busy
);
  localparam logic [15:0] LAST      = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  dout_q, dout_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;
  logic        rx_s, tick, stop_tick;

  uart_rx_sync u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  // START waits half a bit to land mid-start; every later bit waits a full bit.
  assign tick      = cnt_q == ((state_q == ST_START) ? HALF_LAST : LAST);
  assign stop_tick = en && state_q == ST_STOP && tick;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (rx_s == UART_START_BIT) state_d = ST_START;
      ST_START:     if (tick) state_d = (rx_s == UART_START_BIT) ? ST_DATA : ST_IDLE;
`ifdef UART_RX_PARITY_EN
      ST_DATA:      if (tick && bit_q == LAST_BIT) state_d = ST_PARITY;
      ST_PARITY:    if (tick) state_d = ST_STOP;
`else
      ST_DATA:      if (tick && bit_q == LAST_BIT) state_d = ST_STOP;
`endif
      ST_STOP:      if (tick) state_d = (rx_s == UART_STOP_BIT) ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (rx_s == UART_STOP_BIT) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (!en) state_d = ST_IDLE;
  end

  always_comb begin
    cnt_d   = (state_d != state_q || tick || state_q == ST_IDLE || state_q == ST_WAIT_HIGH)
              ? '0 : cnt_q + 16'd1;
    bit_d   = (state_q != ST_DATA) ? '0 : tick ? bit_q + 3'd1 : bit_q;
    shift_d = (state_q == ST_DATA && tick) ? {rx_s, shift_q[7:1]} : shift_q;
    dout_d  = stop_tick ? shift_q : dout_q;
    ferr_d  = stop_tick ? (rx_s != UART_STOP_BIT) : ferr_q;
    done_d  = stop_tick;
  end

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d, err_q, err_d;
  always_ff @(posedge clk_in) begin
    if (rst) begin
      perr_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      perr_q <= perr_d;
      err_q  <= err_d;
    end
  end
  always_comb begin
    perr_d = (en && state_q == ST_PARITY && tick) ? rx_s ^ (^shift_q) : perr_q;
    err_d  = stop_tick ? perr_q : err_q;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    dout      = dout_q;
    done      = done_q;
    frame_err = ferr_q;
    busy      = state_q != ST_IDLE;
  end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed self-checking bench for uart_rx_os; adapts to UART_RX_PARITY_EN.
module tb_uart_rx_os;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int  FB  = 11;
  localparam logic PAR = 1'b1;
`else
  localparam int  FB  = 10;
  localparam logic PAR = 1'b0;
`endif
  localparam int NOCUT = 1 << 30;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       done, err, frame_err, busy;

  int total = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int prev_done_cyc = 0;
  logic [7:0] prev_dout = '0;
  logic [7:0] last_dout = '0;
  int base;

  uart_rx_os #(.CLKS_PER_BIT(CPB)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .rx        (rx),
    .dout      (dout),
    .done      (done),
    .err       (err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (done) begin
      done_cnt      = done_cnt + 1;
      prev_done_cyc = done_cyc;
      done_cyc      = cyc;
      prev_dout     = last_dout;
      last_dout     = dout;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Drives one frame LSB first; stops driving (line back high) after 'cut' clocks.
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop, input int cut);
    logic [10:0] fr;
`ifdef UART_RX_PARITY_EN
    fr = {stop, (^d) ^ par_flip, d, 1'b0};
`else
    fr = {1'b1, stop, d, 1'b0};
`endif
    for (int i = 0; i < FB * CPB && i < cut; i++) begin
      rx = fr[i / CPB];
      @(negedge clk_in);
    end
    rx = 1'b1;
  endtask

  initial begin
    idle(4);
    chk("rst_dout", dout, 8'h00);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    idle(4);

    send_frame(8'hA5, 1'b0, 1'b1, NOCUT);
    idle(5);
    chk("a5_cnt", done_cnt, 1);
    chk("a5_dout", dout, 8'hA5);
    chk("a5_err", err, 0);
    chk("a5_ferr", frame_err, 0);
    chk("a5_busy", busy, 0);

    send_frame(8'h3C, 1'b1, 1'b1, NOCUT);
    idle(5);
    chk("3c_cnt", done_cnt, 2);
    chk("3c_dout", dout, 8'h3C);
    chk("3c_err", err, int'(PAR));
    send_frame(8'h01, 1'b0, 1'b1, NOCUT);
    idle(5);
    chk("01_dout", dout, 8'h01);
    chk("01_err", err, 0);

    send_frame(8'h55, 1'b0, 1'b0, NOCUT);
    rx = 1'b0;
    idle(40);
    chk("55_cnt", done_cnt, 4);
    chk("55_dout", dout, 8'h55);
    chk("55_ferr", frame_err, 1);
    chk("55_busy_low", busy, 1);
    rx = 1'b1;
    idle(6);
    chk("55_busy_rel", busy, 0);
    chk("55_no_extra", done_cnt, 4);

    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(3);
    chk("gl_busy_hi", busy, 1);
    idle(7);
    chk("gl_busy_lo", busy, 0);
    idle(20);
    chk("gl_no_done", done_cnt, 4);

    send_frame(8'h00, 1'b0, 1'b1, NOCUT);
    send_frame(8'hFF, 1'b0, 1'b1, NOCUT);
    idle(5);
    chk("b2b_cnt", done_cnt, 6);
    chk("b2b_gap", done_cyc - prev_done_cyc, FB * CPB);
    chk("b2b_first", prev_dout, 8'h00);
    chk("b2b_second", dout, 8'hFF);

    send_frame(8'h81, 1'b0, 1'b1, 60);
    rst = 1'b1;
    idle(1);
    chk("mrst_dout", dout, 8'h00);
    chk("mrst_err", err, 0);
    chk("mrst_ferr", frame_err, 0);
    chk("mrst_busy", busy, 0);
    rst = 1'b0;
    idle(200);
    chk("mrst_no_done", done_cnt, 6);
    send_frame(8'h81, 1'b0, 1'b1, NOCUT);
    idle(5);
    chk("81_cnt", done_cnt, 7);
    chk("81_dout", dout, 8'h81);

    send_frame(8'h3C, 1'b1, 1'b1, NOCUT);
    idle(5);
    base = done_cnt;
    send_frame(8'h81, 1'b0, 1'b1, 60);
    en = 1'b0;
    idle(3);
    chk("en_busy", busy, 0);
    en = 1'b1;
    idle(200);
    chk("en_no_done", done_cnt, base);
    chk("en_dout_keep", dout, 8'h3C);
    chk("en_err_keep", err, int'(PAR));
    send_frame(8'h81, 1'b0, 1'b1, NOCUT);
    idle(5);
    chk("en81_cnt", done_cnt, base + 1);
    chk("en81_dout", dout, 8'h81);
    chk("en81_err", err, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver for the serial link driven by the team's bit-per-clock UART transmitter. It recovers frames of one start bit, 8 data bits (LSB first), an optional even-parity bit and one stop bit from an asynchronous `rx` line. Each bit spans `CLKS_PER_BIT` clocks. The block presents the received byte with parity and framing status on a single-cycle `done` strobe, and sits between the pad-side `rx` pin and the byte consumer.

## Interface
- `CLKS_PER_BIT`, 16: clocks per serial bit.
  - Legal range is 4 to 65535.
  - Mid-bit offset is `CLKS_PER_BIT/2`, rounded down.
- `clk_in`  input  1: single clock; all logic is on its rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `en`  input  1: receiver enable. When 0, the block is held in IDLE.
- `rx`  input  1: asynchronous serial input, idle high.
- `dout`  output  8: received byte. Holds its value until the next `done`.
- `done`  output  1: one-cycle strobe; `dout`, `err` and `frame_err` are valid in that cycle.
- `err`  output  1: parity error of the last frame. Holds until the next `done`.
- `frame_err`  output  1: stop bit was sampled low. Holds until the next `done`.
- `busy`  output  1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - Sample counter and bit counter are cleared.
  - If `en=1` and `rx_s=0`, go to START.
- START: count `CLKS_PER_BIT/2` clocks to mid-start, then sample `rx_s`.
  - `rx_s=1`: false start; return to IDLE with no `done`.
  - `rx_s=0`: go to DATA with the sample counter cleared.
- DATA:
  - Every `CLKS_PER_BIT` clocks, sample `rx_s` into a shift register, LSB first.
  - After the 8th sample, go to PARITY (or to STOP when parity is compiled out).
- PARITY: after `CLKS_PER_BIT` clocks, sample the parity bit.
  - `perr = sample ^ (^shift)`, i.e. even parity.
- STOP: after `CLKS_PER_BIT` clocks, sample the stop bit.
  - Next cycle: `dout<=shift`, `err<=perr`, `frame_err<=~stop_sample`, `done<=1`.
  - Stop sampled 1: go to IDLE; a new start can be accepted in the same cycle.
  - Stop sampled 0: go to WAIT_HIGH.
- WAIT_HIGH: remain until `rx_s=1`, then go to IDLE. This absorbs break conditions.
- `en` falling in any non-IDLE state: abort to IDLE. No `done`; `dout`/`err`/`frame_err` are unchanged.
- `rst=1` at any point, including mid-frame, forces the following; it has priority over `en`:
  - state: IDLE
  - counters: 0
  - `dout`: 0x00
  - `done`: 0
  - `err`: 0
  - `frame_err`: 0
  - `busy`: 0
  - synchronizer flops: 1

## Timing
- Start detection: `rx_s` lags `rx` by 2 clocks; START is entered 1 clock after `rx_s` falls.
- Sample instants, counted from the first clock in START:
  - start: `CLKS_PER_BIT/2`
  - data bit k: `CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT`, k = 0..7
  - parity: `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT`
  - stop: `CLKS_PER_BIT/2 + 10*CLKS_PER_BIT` (with parity) or `+ 9*CLKS_PER_BIT` (without)
- `done` is high for exactly one clock, one clock after the stop sample.
- `busy` rises with entry to START. It falls on the clock `done` is high when the next state is IDLE, otherwise on leaving WAIT_HIGH.
- Back-to-back frames with no idle gap after the stop bit are received without loss.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- Defined:
  - 11-bit frame; PARITY state is present.
  - `err` reports even-parity mismatch.
- Undefined:
  - 10-bit frame; DATA goes directly to STOP.
  - `err` is constant 0.
- Must match the transmitter's build.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_rx_state_t`
  - `UART_DATA_BITS = 8`
  - `UART_START_BIT = 1'b0`
  - `UART_STOP_BIT = 1'b1`
- One sub-module, `uart_rx_sync`: 2-flop synchronizer with reset value 1, reusable for other asynchronous inputs.

## Test plan
All scenarios use `CLKS_PER_BIT=16` and `UART_RX_PARITY_EN` defined unless stated.
- Send 0xA5 with parity 0 and stop 1 -> one `done` pulse, `dout=0xA5`, `err=0`, `frame_err=0`, `busy` returns to 0.
- Send 0x3C with parity bit forced to 1 -> `done`, `dout=0x3C`, `err=1`. Then a clean 0x01 frame (parity 1) -> `err` returns to 0.
- Send 0x55 with stop=0, rx held low 40 clocks -> `done`, `frame_err=1`. `busy` stays high until rx goes high; no further `done`.
- rx low for 5 clocks then high (glitch) -> no `done`, `busy` back to 0 before the 10th clock.
- Frames 0x00 then 0xFF with no gap -> two `done` pulses 176 clocks apart, `dout` 0x00 then 0xFF. Macro undefined: 160 clocks apart.
- `rst` pulsed mid-DATA of 0x81, or `en` dropped mid-DATA -> no `done`, outputs at reset values or unchanged respectively. The next clean 0x81 frame is received correctly.
